// File: rtl/rf_writeback_pkg.sv
// Shared types for the register-bank write port: data/address widths and the
// late-result entry that is buffered until the write port is free.
package rf_writeback_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xdata_t;

    typedef struct packed {
        reg_addr_t addr;
        xdata_t    data;
    } late_entry_t;

    // One-hot register mask; r0 is hard-wired and never represented.
    function automatic logic [XLEN-1:0] reg_mask(input reg_addr_t a);
        logic [XLEN-1:0] m;
        m = '0;
        if (a != REG_ZERO) m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_writeback_if.sv
// Bundle of writeback, issue, late-result, decode-probe and bank-write signals.
// master = pipeline/long-latency side driving requests; slave = rf_writeback.
interface rf_writeback_if;
    import rf_writeback_pkg::*;

    logic      wb_wren;
    reg_addr_t wb_addr;
    xdata_t    wb_data;
    logic      iss_valid;
    reg_addr_t iss_addr;
    logic      lr_valid;
    reg_addr_t lr_addr;
    xdata_t    lr_data;
    logic      lr_ready;
    reg_addr_t rd_a_addr;
    reg_addr_t rd_b_addr;
    logic      hazard;
    logic      stall_req;
    logic      rf_wren;
    reg_addr_t rf_addr;
    xdata_t    rf_data;
    logic [XLEN-1:0] busy;

    modport master (
        output wb_wren, wb_addr, wb_data, iss_valid, iss_addr,
               lr_valid, lr_addr, lr_data, rd_a_addr, rd_b_addr,
        input  lr_ready, hazard, stall_req, rf_wren, rf_addr, rf_data, busy
    );

    modport slave (
        input  wb_wren, wb_addr, wb_data, iss_valid, iss_addr,
               lr_valid, lr_addr, lr_data, rd_a_addr, rd_b_addr,
        output lr_ready, hazard, stall_req, rf_wren, rf_addr, rf_data, busy
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// In-order buffer of late results waiting for the bank write port.
// Head visible combinationally, 1-cycle push-to-pop; push ignored when full, pop ignored when empty.
module rf_wb_fifo
    import rf_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        push,
    input  late_entry_t push_dat,
    input  logic        pop,
    output late_entry_t head_dat,
    output logic        full,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    late_entry_t    mem_q [DEPTH];
    late_entry_t    mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rf_writeback.sv
// Single bank write port: pipeline writeback has priority, buffered late results fill idle slots.
// 1-cycle pipeline latency, >=2-cycle late latency; lr_ready drops and stall_req rises when buffer full.
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic           clock,
    input  logic           rst,
    rf_writeback_if.slave  bus
);

    logic        wb_take;
    logic        pop;
    logic        push;
    logic        fifo_full;
    logic        fifo_empty;
    late_entry_t head;
    late_entry_t push_entry;

    logic            rf_wren_q, rf_wren_d;
    reg_addr_t       rf_addr_q, rf_addr_d;
    xdata_t          rf_data_q, rf_data_d;
    logic [XLEN-1:0] busy_q, busy_d;

    // A pipeline write to r0 is treated as a bubble so the buffer can drain.
    assign wb_take = bus.wb_wren && (bus.wb_addr != REG_ZERO);
    assign pop     = !wb_take && !fifo_empty;

    assign bus.lr_ready = !fifo_full && !rst;
    // r0 late results are handshaken but never stored.
    assign push         = bus.lr_valid && bus.lr_ready && (bus.lr_addr != REG_ZERO);
    assign push_entry   = '{addr: bus.lr_addr, data: bus.lr_data};

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .rst      (rst),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        rf_wren_d = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (wb_take) begin
            rf_wren_d = 1'b1;
            rf_addr_d = bus.wb_addr;
            rf_data_d = bus.wb_data;
        end else if (pop) begin
            rf_wren_d = 1'b1;
            rf_addr_d = head.addr;
            rf_data_d = head.data;
        end
    end

    // Clear then set, so a new issue survives a same-cycle commit to that register.
    always_comb begin
        busy_d = busy_q;
        if (pop)           busy_d = busy_d & ~reg_mask(head.addr);
        if (bus.iss_valid) busy_d = busy_d | reg_mask(bus.iss_addr);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            rf_wren_q <= 1'b0;
            rf_addr_q <= REG_ZERO;
            rf_data_q <= '0;
            busy_q    <= '0;
        end else begin
            rf_wren_q <= rf_wren_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rf_wren   = rf_wren_q;
    assign bus.rf_addr   = rf_addr_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.busy      = busy_q;
    assign bus.stall_req = fifo_full;
    assign bus.hazard    = ((bus.rd_a_addr != REG_ZERO) && busy_q[bus.rd_a_addr]) ||
                           ((bus.rd_b_addr != REG_ZERO) && busy_q[bus.rd_b_addr]);

endmodule

// File: tb/tb_rf_writeback.sv
// Directed scenarios then random traffic against a queue-based model of the write port.
module tb_rf_writeback;
    import rf_writeback_pkg::*;

    localparam int DEPTH = 2;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    rf_writeback_if bus ();

    rf_writeback #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state
    late_entry_t     mq[$];
    logic [31:0]     m_busy  = '0;
    logic            m_wren  = 1'b0;
    logic [4:0]      m_addr  = '0;
    logic [31:0]     m_data  = '0;
    bit              m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wb_wren   = 1'b0; bus.wb_addr  = '0; bus.wb_data = '0;
        bus.iss_valid = 1'b0; bus.iss_addr = '0;
        bus.lr_valid  = 1'b0; bus.lr_addr  = '0; bus.lr_data = '0;
        bus.rd_a_addr = '0;   bus.rd_b_addr = '0;
    endtask

    function automatic logic exp_hazard();
        return (bus.rd_a_addr != 0 && m_busy[bus.rd_a_addr]) ||
               (bus.rd_b_addr != 0 && m_busy[bus.rd_b_addr]);
    endfunction

    // One clock: check combinational outputs, advance the model at the edge, check registers.
    task automatic step();
        bit          accept;
        late_entry_t e;
        #1;
        if (rst) chk("lr_ready_rst", bus.lr_ready, 1'b0);
        if (m_valid) begin
            chk("lr_ready", bus.lr_ready, (!rst && mq.size() < DEPTH));
            chk("stall_req", bus.stall_req, (mq.size() == DEPTH));
            chk("hazard", bus.hazard, exp_hazard());
        end
        @(posedge clock);
        if (rst) begin
            mq.delete();
            m_busy = '0; m_wren = 1'b0; m_addr = '0; m_data = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            accept = bus.lr_valid && (mq.size() < DEPTH);
            if (bus.wb_wren && bus.wb_addr != 0) begin
                m_wren = 1'b1; m_addr = bus.wb_addr; m_data = bus.wb_data;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_wren = 1'b1; m_addr = e.addr; m_data = e.data;
                m_busy[e.addr] = 1'b0;
            end else begin
                m_wren = 1'b0;
            end
            if (accept && bus.lr_addr != 0) mq.push_back('{addr: bus.lr_addr, data: bus.lr_data});
            if (bus.iss_valid && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
        end
        #1;
        if (m_valid) begin
            chk("rf_wren", bus.rf_wren, m_wren);
            chk("rf_addr", bus.rf_addr, m_addr);
            chk("rf_data", bus.rf_data, m_data);
            chk("busy", bus.busy, m_busy);
        end
        @(negedge clock);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        chk("reset_rf_wren", bus.rf_wren, 1'b0);
        chk("reset_busy", bus.busy, 32'h0);
        rst = 1'b0;

        // Pipeline only
        bus.wb_wren = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234;
        step();
        chk("pipe_wren", bus.rf_wren, 1'b1);
        chk("pipe_addr", bus.rf_addr, 32'd5);
        chk("pipe_data", bus.rf_data, 32'h1234);
        bus.wb_addr = 5'd0;
        step();
        chk("pipe_r0_wren", bus.rf_wren, 1'b0);
        chk("pipe_r0_hold", bus.rf_addr, 32'd5);

        // Late path to r9
        idle();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
        step();
        idle();
        bus.rd_a_addr = 5'd9;
        #1 chk("late_hazard_set", bus.hazard, 1'b1);
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd9; bus.lr_data = 32'hDEAD;
        step();
        chk("late_busy9_pending", bus.busy[9], 1'b1);
        chk("late_not_yet", bus.rf_wren, 1'b0);
        bus.lr_valid = 1'b0;
        step();
        chk("late_commit_addr", bus.rf_addr, 32'd9);
        chk("late_commit_data", bus.rf_data, 32'hDEAD);
        chk("late_busy9_clr", bus.busy[9], 1'b0);
        chk("late_hazard_clr", bus.hazard, 1'b0);

        // Contention: continuous pipeline writes, three late results
        idle();
        bus.wb_wren = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'h11;
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd10; bus.lr_data = 32'hA;
        step();
        bus.wb_addr = 5'd2; bus.wb_data = 32'h22;
        bus.lr_addr = 5'd11; bus.lr_data = 32'hB;
        step();
        chk("cont_lr_ready_full", bus.lr_ready, 1'b0);
        chk("cont_stall", bus.stall_req, 1'b1);
        bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
        bus.lr_addr = 5'd12; bus.lr_data = 32'hC;
        step();
        chk("cont_still_stall", bus.stall_req, 1'b1);
        chk("cont_pipe_won", bus.rf_addr, 32'd3);
        bus.wb_wren = 1'b0;
        step();
        chk("cont_head_addr", bus.rf_addr, 32'd10);
        chk("cont_head_data", bus.rf_data, 32'hA);
        chk("cont_lr_ready_back", bus.lr_ready, 1'b1);
        step();
        chk("cont_second", bus.rf_addr, 32'd11);
        bus.lr_valid = 1'b0;
        step();
        chk("cont_third", bus.rf_data, 32'hC);
        step();
        chk("cont_drained", bus.rf_wren, 1'b0);

        // Simultaneous set and clear on r7
        idle();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
        step();
        idle();
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd7; bus.lr_data = 32'h77;
        step();
        idle();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd7;
        step();
        chk("setclr_commit", bus.rf_addr, 32'd7);
        chk("setclr_busy7", bus.busy[7], 1'b1);
        idle();
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd7; bus.lr_data = 32'h78;
        step();
        idle();
        step();
        chk("setclr_final", bus.busy[7], 1'b0);

        // Late result to r0
        idle();
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd0; bus.lr_data = 32'hBAD0;
        #1 chk("r0_lr_ready", bus.lr_ready, 1'b1);
        step();
        idle();
        step();
        chk("r0_no_write", bus.rf_wren, 1'b0);
        chk("r0_busy", bus.busy, 32'h0);

        // Reset with two buffered entries and r8/r9 busy
        idle();
        bus.iss_valid = 1'b1; bus.iss_addr = 5'd8;
        step();
        bus.iss_addr = 5'd9;
        step();
        idle();
        bus.wb_wren = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h44;
        bus.lr_valid = 1'b1; bus.lr_addr = 5'd8; bus.lr_data = 32'h88;
        step();
        bus.lr_addr = 5'd9; bus.lr_data = 32'h99;
        step();
        chk("rst_pre_busy", bus.busy, 32'h0000_0300);
        chk("rst_pre_full", bus.stall_req, 1'b1);
        bus.lr_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_rf_wren", bus.rf_wren, 1'b0);
        chk("rst_rf_addr", bus.rf_addr, 32'd0);
        chk("rst_rf_data", bus.rf_data, 32'd0);
        chk("rst_busy", bus.busy, 32'h0);
        chk("rst_stall", bus.stall_req, 1'b0);
        idle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_quiet", bus.rf_wren, 1'b0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 63) == 0);
            bus.wb_wren   = ($urandom_range(0, 2) != 0);
            bus.wb_addr   = 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            bus.iss_valid = ($urandom_range(0, 3) == 0);
            bus.iss_addr  = 5'($urandom_range(0, 7));
            bus.lr_valid  = ($urandom_range(0, 1) == 0);
            bus.lr_addr   = 5'($urandom_range(0, 7));
            bus.lr_data   = $urandom;
            bus.rd_a_addr = 5'($urandom_range(0, 7));
            bus.rd_b_addr = 5'($urandom_range(0, 7));
            step();
        end
        rst = 1'b0;
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-side owner of the register bank's single write port: merges the in-order pipeline writeback with out-of-order late results (loads from slow memory, multi-cycle mul/div) into one registered write stream. It drives the bank's `data`/`wraddress`/`wren` inputs. It also keeps a scoreboard of registers awaiting a late result, so decode can raise a read hazard. It sits between the WB stage / long-latency units and the register array.

## Interface
- `DEPTH`, 2, late-result buffer entries (power of 2, ≥2)
- `clock`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wb_wren`  in  1  pipeline writeback valid; always accepted, never back-pressured
- `wb_addr`  in  5  pipeline destination register
- `wb_data`  in  32  pipeline result
- `iss_valid`  in  1  long-latency op issued; marks `iss_addr` busy
- `iss_addr`  in  5  destination of issued op
- `lr_valid`  in  1  late result valid
- `lr_addr`  in  5  late result destination
- `lr_data`  in  32  late result value
- `lr_ready`  out  1  late result accepted when `lr_valid && lr_ready`
- `rd_a_addr`, `rd_b_addr`  in  5 each  decode source registers
- `hazard`  out  1  a source register is busy
- `stall_req`  out  1  buffer full; control must insert a WB bubble
- `rf_wren`  out  1  to bank `wren`
- `rf_addr`  out  5  to bank `wraddress`
- `rf_data`  out  32  to bank `data`
- `busy`  out  32  scoreboard, bit n = register n pending

## Operation
- Arbitration each cycle, priority order:
  - Pipeline first, if `wb_wren && wb_addr!=0`.
  - Else buffer head, if the buffer is non-empty; the head is popped.
  - Else idle, with `rf_wren=0`.
- Result is registered into `rf_*`. `rf_addr`/`rf_data` hold their last values when idle.
- Writes to r0 are dropped everywhere:
  - A pipeline write to r0 counts as no write, so the buffer may drain that cycle.
  - A late result to r0 is accepted and discarded (not pushed).
  - An issue to r0 sets nothing.
- Buffer: in-order FIFO of {addr, data}.
  - `lr_ready = !full && !rst`. No same-cycle pass-through when full.
  - Push and pop in the same cycle leave the count unchanged.
- Scoreboard:
  - Set: `busy[iss_addr]` on `iss_valid`.
  - Clear: the bit for `rf_addr` at the commit of a buffer-sourced write.
  - Set and clear of the same register in the same cycle: set wins.
  - No counts are kept. Issuing to an already-busy register is an upstream error; the first completion clears the bit.
  - Pipeline writes never touch `busy`.
- `hazard = (rd_a_addr!=0 && busy[rd_a_addr]) || (rd_b_addr!=0 && busy[rd_b_addr])`. Combinational from the `busy` register only.
- `stall_req = full`. Combinational from the count register.
- WAW ordering between pipeline and late writes is the issuer's job, enforced via `hazard`. This block does not check it.

## Timing
- Reset, while `rst` is high and on the first edge:
  - `rf_wren=0`, `rf_addr=0`, `rf_data=0`
  - buffer empty, `busy=0`, `lr_ready=0`, `stall_req=0`, `hazard=0`
- `rst` mid-operation discards buffered results and clears the scoreboard. Nothing is written to the bank.
- Pipeline latency: `wb_*` sampled at edge N appears on `rf_*` after edge N, i.e. 1 cycle.
- Late latency: accepted at edge N, earliest commit on `rf_*` after edge N+1, i.e. 2 cycles. Each cycle of pipeline writeback adds 1 cycle.
- `busy` bit for a late result clears after the edge that makes its `rf_wren` visible. `hazard` drops in that same cycle.
- Full buffer with continuous pipeline writes: `lr_ready=0` and `stall_req=1` until a bubble (`wb_wren=0` or `wb_addr=0`) lets the head drain.

## Structure
- Shared package holds `XLEN=32`, `REG_AW=5`, `REG_ZERO=5'd0`, and the late-entry struct {addr, data}. The ext/compare/pc_gen controls are untouched.
- One sub-module: `rf_wb_fifo`, a synchronous FIFO with `DEPTH` entries of 37 bits, full/empty flags, and pointers that wrap modulo `DEPTH`.
- The top level holds the arbiter, output registers and scoreboard.

## Test plan
- Pipeline only: `wb_wren=1`, addr 5, data 0x1234 at edge 0 → `rf_wren=1`, `rf_addr=5`, `rf_data=0x1234` after edge 0. The same stimulus with addr 0 → `rf_wren=0`.
- Late path: `iss_valid` addr 9, then `lr` addr 9 data 0xDEAD accepted at edge 3 with pipeline idle:
  - `busy[9]=1` and `hazard=1` for `rd_a_addr=9` until the commit.
  - Commit `rf_addr=9`, `rf_data=0xDEAD` after edge 4.
  - `busy[9]=0` in the same cycle.
- Contention: pipeline writes every cycle while 3 late results are offered, `DEPTH=2`:
  - 2 accepted, third sees `lr_ready=0` and `stall_req=1`.
  - One bubble commits the head in order, and `lr_ready` returns.
- Simultaneous set/clear: a commit to r7 in the same cycle as `iss_valid` addr 7 → `busy[7]` stays 1.
- Late result to r0 → accepted, never written, `busy` unchanged, buffer count unchanged.
- Reset mid-operation with 2 buffered entries and `busy=0x0000_0300` → all outputs at reset values next cycle. No `rf_wren` appears after release until new traffic arrives.
